btb: RTL and testbench
======================

Name: btb

Overview:
- Branch target buffer: the prediction source that creates branchpredict_sbe hints for the fetch stage.
- It also consumes the branchpredict resolution struct returned from the ex stage.
- Direct-mapped table of NR_ENTRIES entries. Each entry holds a tag, target, is_lower_16 flag and 2-bit saturating counter.
- Lookup is combinational off registered state. Updates, clears and flushes take effect at the next rising clock edge.

Parameters:
- NR_ENTRIES, 64, number of table entries; power of two, >= 2.
- INDEX_BITS, $clog2(NR_ENTRIES), index width; derived, do not override.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- flush_i  in  1  invalidate the whole table.
- vpc_i  in  64  fetch PC to look up.
- lookup_valid_i  in  1  vpc_i is valid this cycle.
- bp_update_i  in  branchpredict  resolution from ex stage (pc, target_address, is_mispredict, is_taken, is_lower_16, valid, clear).
- branch_predict_o  out  branchpredict_sbe  prediction for vpc_i (predict_address, predict_taken, is_lower_16, valid).

Behaviour:
- Address split:
  - index = pc[INDEX_BITS+1:2], 32-bit fetch-word granularity.
  - tag = pc[63:INDEX_BITS+2].
  - pc[1] is ignored for indexing; is_lower_16 distinguishes halves.
- Entry fields: valid, tag, target[63:0], is_lower_16, cnt[1:0].
- Reset (rst_i=1 at edge), all entries:
  - valid=0, tag=0, target=0, is_lower_16=0, cnt=2'b01.
  - Output is combinational, so branch_predict_o is all-zero in the cycle after reset.
- Lookup, same cycle, no latency:
  - hit = lookup_valid_i & entry.valid & (entry.tag == tag(vpc_i)).
  - On hit: valid=1, predict_address=entry.target, predict_taken=entry.cnt[1], is_lower_16=entry.is_lower_16.
  - On miss: all fields 0.
- Update, when bp_update_i.valid=1 & bp_update_i.clear=0, at index/tag of bp_update_i.pc:
  - Hit and is_taken: cnt=min(cnt+1,3); target=target_address; is_lower_16 updated.
  - Hit and not taken: cnt=max(cnt-1,0); target unchanged.
  - Miss and is_taken: allocate/overwrite (aliasing entry evicted). valid=1, tag, target, is_lower_16, cnt=2'b10.
  - Miss and not taken: no change.
  - is_mispredict does not alter the update rule; the counter captures it.
- Clear, when bp_update_i.valid=1 & clear=1:
  - Invalidate the entry at index only if it is valid and the tag matches; otherwise no effect.
- Priority at a single edge: rst_i > flush_i > clear > update.
  - flush_i clears all valid bits in one cycle and drops a same-cycle update.
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents (no bypass). The new contents are visible the following cycle.
- Reset mid-operation: wipes everything, including a concurrent update.
- Arithmetic: the counter saturates; it never wraps from 3→0 or 0→3.

Decomposition:
- Shared package (ariane_pkg):
  - btb_entry typedef (valid, tag, target, is_lower_16, cnt).
  - BTB_ENTRIES constant (default 64).
  - Function for the 2-bit saturating counter update (taken/not-taken in, next cnt out).
- Sub-module: none. The table is a flat register array with one write port in a single always_ff, with read muxes in always_comb.

Test Plan:
- Reset, then lookup vpc_i=0x8000_0000, lookup_valid_i=1 -> branch_predict_o.valid=0, predict_address=0, predict_taken=0.
- Update pc=0x8000_0010, is_taken=1, target=0x8000_0100, is_lower_16=1, then lookup 0x8000_0010 and 0x8000_0012 -> both valid=1, predict_taken=1, predict_address=0x8000_0100, is_lower_16=1. The same-cycle lookup during the update shows valid=0.
- Aliasing (index 4): lookup 0x8000_0110 after the previous step -> valid=0. Taken update pc=0x8000_0110, target=0x8000_0200 -> 0x8000_0110 hits with 0x8000_0200, and 0x8000_0010 now misses.
- Counter: allocated entry cnt=10; not-taken x3 -> cnt 01,00,00 with predict_taken 0 throughout; taken x3 -> 01,10,11 with predict_taken 0,1,1; target kept from the last taken update.
- Clear: clear=1 at pc=0x8000_0110 -> next-cycle lookup valid=0. Clear at a tag-mismatched pc (0x9000_0110) on a valid entry -> entry still hits.
- Flush plus update in the same cycle -> every previously valid PC misses and the updated PC also misses. rst_i asserted for 1 cycle mid-stream -> all lookups miss, and a new taken update allocates with cnt=10.

Source files
------------

// File: rtl/ariane_pkg.sv
// Shared types for the branch target buffer: ex-stage resolution, fetch-stage
// prediction hint, table entry layout and the 2-bit saturating counter rule.
package ariane_pkg;

  localparam int unsigned BTB_ENTRIES = 64;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] target_address;
    logic        is_mispredict;
    logic        is_taken;
    logic        is_lower_16;
    logic        valid;
    logic        clear;
  } branchpredict;

  typedef struct packed {
    logic        valid;
    logic [63:0] predict_address;
    logic        predict_taken;
    logic        is_lower_16;
  } branchpredict_sbe;

  // Tag is held at full width; bits above the live tag range stay zero.
  typedef struct packed {
    logic        valid;
    logic [63:0] tag;
    logic [63:0] target;
    logic        is_lower_16;
    logic [1:0]  cnt;
  } btb_entry;

  localparam btb_entry BTB_ENTRY_RESET = '{
    valid:       1'b0,
    tag:         '0,
    target:      '0,
    is_lower_16: 1'b0,
    cnt:         2'b01
  };

  function automatic logic [1:0] sat_cnt_update(input logic [1:0] cnt,
                                                 input logic       taken);
    logic [1:0] nxt;
    nxt = cnt;
    if (taken) begin
      if (cnt != 2'b11) nxt = cnt + 2'b01;
    end else begin
      if (cnt != 2'b00) nxt = cnt - 2'b01;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/btb.sv
// Direct-mapped branch target buffer: combinational lookup off registered
// state, single write port for ex-stage updates, clears and whole-table flush.
module btb
  import ariane_pkg::*;
#(
  parameter int unsigned NR_ENTRIES = BTB_ENTRIES,
  parameter int unsigned INDEX_BITS = $clog2(NR_ENTRIES)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic [63:0]      vpc_i,
  input  logic             lookup_valid_i,
  input  branchpredict     bp_update_i,
  output branchpredict_sbe branch_predict_o
);

  btb_entry btb_q [NR_ENTRIES];
  btb_entry btb_d [NR_ENTRIES];

  logic [INDEX_BITS-1:0] lk_idx;
  logic [INDEX_BITS-1:0] upd_idx;
  logic [63:0]           lk_tag;
  logic [63:0]           upd_tag;
  btb_entry              lk_entry;
  btb_entry              upd_entry;
  logic                  lk_hit;
  logic                  upd_hit;

  function automatic logic [63:0] tag_of(input logic [63:0] pc);
    return pc >> (INDEX_BITS + 2);
  endfunction

  // pc[1] never reaches index or tag: both halves of a fetch word share an entry.
  logic unused_ok;
  assign unused_ok = ^{vpc_i[1:0], bp_update_i.pc[1:0], bp_update_i.is_mispredict};

  always_comb begin
    lk_idx   = vpc_i[INDEX_BITS+1:2];
    lk_tag   = tag_of(vpc_i);
    lk_entry = btb_q[lk_idx];
    lk_hit   = lookup_valid_i && lk_entry.valid && (lk_entry.tag == lk_tag);

    branch_predict_o = '0;
    if (lk_hit) begin
      branch_predict_o.valid           = 1'b1;
      branch_predict_o.predict_address = lk_entry.target;
      branch_predict_o.predict_taken   = lk_entry.cnt[1];
      branch_predict_o.is_lower_16     = lk_entry.is_lower_16;
    end
  end

  always_comb begin
    upd_idx   = bp_update_i.pc[INDEX_BITS+1:2];
    upd_tag   = tag_of(bp_update_i.pc);
    upd_entry = btb_q[upd_idx];
    upd_hit   = upd_entry.valid && (upd_entry.tag == upd_tag);

    for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
      btb_d[i] = btb_q[i];
    end

    if (flush_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        btb_d[i].valid = 1'b0;
      end
    end else if (bp_update_i.valid && bp_update_i.clear) begin
      if (upd_hit) btb_d[upd_idx].valid = 1'b0;
    end else if (bp_update_i.valid) begin
      if (upd_hit) begin
        btb_d[upd_idx].cnt = sat_cnt_update(upd_entry.cnt, bp_update_i.is_taken);
        if (bp_update_i.is_taken) begin
          btb_d[upd_idx].target      = bp_update_i.target_address;
          btb_d[upd_idx].is_lower_16 = bp_update_i.is_lower_16;
        end
      end else if (bp_update_i.is_taken) begin
        // Allocation overwrites whatever aliased into this slot.
        btb_d[upd_idx].valid       = 1'b1;
        btb_d[upd_idx].tag         = upd_tag;
        btb_d[upd_idx].target      = bp_update_i.target_address;
        btb_d[upd_idx].is_lower_16 = bp_update_i.is_lower_16;
        btb_d[upd_idx].cnt         = 2'b10;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        btb_q[i] <= BTB_ENTRY_RESET;
      end
    end else begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        btb_q[i] <= btb_d[i];
      end
    end
  end

endmodule

// File: tb/tb_btb.sv
// Self-checking bench for btb: directed scenarios plus randomized traffic,
// all compared against an array-based reference model of the table.
module tb_btb;
  import ariane_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic [63:0]      vpc;
  logic             lv;
  branchpredict     upd;
  branchpredict_sbe bp_o;

  int checks = 0;
  int failures = 0;

  bit              m_valid [64];
  longint unsigned m_tag   [64];
  longint unsigned m_tgt   [64];
  bit              m_l16   [64];
  int              m_cnt   [64];

  btb #(.NR_ENTRIES(64)) dut (
    .clk_i            (clk),
    .rst_i            (rst),
    .flush_i          (flush),
    .vpc_i            (vpc),
    .lookup_valid_i   (lv),
    .bp_update_i      (upd),
    .branch_predict_o (bp_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic branchpredict_sbe model_predict(input longint unsigned pc, input bit valid_in);
    branchpredict_sbe p;
    int unsigned i;
    i = int'((pc / 4) % 64);
    p = '0;
    if (valid_in && m_valid[i] && m_tag[i] == pc / 256) begin
      p.valid           = 1'b1;
      p.predict_address = m_tgt[i];
      p.predict_taken   = (m_cnt[i] >= 2);
      p.is_lower_16     = m_l16[i];
    end
    return p;
  endfunction

  function automatic void model_edge();
    int unsigned i;
    longint unsigned pc;
    bit hit;
    pc = upd.pc;
    i = int'((pc / 4) % 64);
    hit = m_valid[i] && (m_tag[i] == pc / 256);
    if (rst) begin
      for (int k = 0; k < 64; k++) begin
        m_valid[k] = 0; m_tag[k] = 0; m_tgt[k] = 0; m_l16[k] = 0; m_cnt[k] = 1;
      end
    end else if (flush) begin
      for (int k = 0; k < 64; k++) m_valid[k] = 0;
    end else if (upd.valid && upd.clear) begin
      if (hit) m_valid[i] = 0;
    end else if (upd.valid) begin
      if (hit && upd.is_taken) begin
        m_cnt[i] = (m_cnt[i] == 3) ? 3 : m_cnt[i] + 1;
        m_tgt[i] = upd.target_address;
        m_l16[i] = upd.is_lower_16;
      end else if (hit) begin
        m_cnt[i] = (m_cnt[i] == 0) ? 0 : m_cnt[i] - 1;
      end else if (upd.is_taken) begin
        m_valid[i] = 1; m_tag[i] = pc / 256; m_tgt[i] = upd.target_address;
        m_l16[i] = upd.is_lower_16; m_cnt[i] = 2;
      end
    end
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    rst = 1'b0;
    flush = 1'b0;
    upd = '0;
  endtask

  task automatic set_upd(input logic [63:0] pc, input logic [63:0] tgt, input logic taken,
                         input logic l16, input logic clr);
    upd = '0;
    upd.pc = pc;
    upd.target_address = tgt;
    upd.is_taken = taken;
    upd.is_mispredict = taken;
    upd.is_lower_16 = l16;
    upd.valid = 1'b1;
    upd.clear = clr;
  endtask

  task automatic look(input logic [63:0] pc);
    vpc = pc;
    lv = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    branchpredict_sbe exp;
    rst = 1'b1; flush = 1'b0; upd = '0; lv = 1'b0; vpc = '0;
    cycle();
    look(64'h8000_0000);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o !== '0) begin
      failures++;
      $display("FAIL reset_lookup got=%h exp=%h", bp_o, exp);
    end
  endtask

  task automatic test_alloc();
    branchpredict_sbe exp;
    set_upd(64'h8000_0010, 64'h8000_0100, 1'b1, 1'b1, 1'b0);
    look(64'h8000_0010);
    checks++;
    if (bp_o.valid !== 1'b0) begin
      failures++;
      $display("FAIL alloc_same_cycle got=%b exp=0", bp_o.valid);
    end
    cycle();
    look(64'h8000_0010);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.predict_address !== 64'h8000_0100) begin
      failures++;
      $display("FAIL alloc_hit got=%h exp=%h", bp_o, exp);
    end
    look(64'h8000_0012);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.is_lower_16 !== 1'b1 || bp_o.predict_taken !== 1'b1) begin
      failures++;
      $display("FAIL alloc_upper_half got=%h exp=%h", bp_o, exp);
    end
  endtask

  task automatic test_alias();
    branchpredict_sbe exp;
    look(64'h8000_0110);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.valid !== 1'b0) begin
      failures++;
      $display("FAIL alias_miss got=%h exp=%h", bp_o, exp);
    end
    set_upd(64'h8000_0110, 64'h8000_0200, 1'b1, 1'b0, 1'b0);
    cycle();
    look(64'h8000_0110);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.predict_address !== 64'h8000_0200) begin
      failures++;
      $display("FAIL alias_new_hit got=%h exp=%h", bp_o, exp);
    end
    look(64'h8000_0010);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.valid !== 1'b0) begin
      failures++;
      $display("FAIL alias_evicted got=%h exp=%h", bp_o, exp);
    end
  endtask

  task automatic test_counter();
    branchpredict_sbe exp;
    logic [2:0] nt_exp = 3'b000;
    logic [2:0] t_exp  = 3'b110;
    for (int k = 0; k < 3; k++) begin
      set_upd(64'h8000_0110, 64'hdead_beef_0000_0000, 1'b0, 1'b1, 1'b0);
      cycle();
      look(64'h8000_0110);
      exp = model_predict(vpc, lv);
      checks++;
      if (bp_o !== exp || bp_o.predict_taken !== nt_exp[k] || bp_o.predict_address !== 64'h8000_0200) begin
        failures++;
        $display("FAIL counter_not_taken_%0d got=%h exp=%h", k, bp_o, exp);
      end
    end
    for (int k = 0; k < 3; k++) begin
      set_upd(64'h8000_0110, 64'h8000_0300 + 64'(4 * k), 1'b1, 1'b0, 1'b0);
      cycle();
      look(64'h8000_0110);
      exp = model_predict(vpc, lv);
      checks++;
      if (bp_o !== exp || bp_o.predict_taken !== t_exp[k]) begin
        failures++;
        $display("FAIL counter_taken_%0d got=%h exp=%h", k, bp_o, exp);
      end
    end
    set_upd(64'h8000_0110, 64'h1234, 1'b0, 1'b1, 1'b0);
    cycle();
    look(64'h8000_0110);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.predict_address !== 64'h8000_0308 || bp_o.predict_taken !== 1'b1) begin
      failures++;
      $display("FAIL counter_target_kept got=%h exp=%h", bp_o, exp);
    end
  endtask

  task automatic test_clear();
    branchpredict_sbe exp;
    set_upd(64'h9000_0110, '0, 1'b0, 1'b0, 1'b1);
    cycle();
    look(64'h8000_0110);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.valid !== 1'b1) begin
      failures++;
      $display("FAIL clear_tag_mismatch got=%h exp=%h", bp_o, exp);
    end
    set_upd(64'h8000_0110, '0, 1'b1, 1'b0, 1'b1);
    cycle();
    look(64'h8000_0110);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.valid !== 1'b0) begin
      failures++;
      $display("FAIL clear_hit got=%h exp=%h", bp_o, exp);
    end
  endtask

  task automatic test_flush();
    branchpredict_sbe exp;
    logic [63:0] pcs [$];
    pcs = '{64'h8000_0020, 64'h8000_0024, 64'h8000_1028, 64'h8000_002e};
    foreach (pcs[k]) begin
      set_upd(pcs[k], pcs[k] + 64'h400, 1'b1, pcs[k][1], 1'b0);
      cycle();
    end
    look(pcs[3]);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.valid !== 1'b1) begin
      failures++;
      $display("FAIL flush_prefill got=%h exp=%h", bp_o, exp);
    end
    flush = 1'b1;
    set_upd(64'h8000_0040, 64'h8000_0800, 1'b1, 1'b0, 1'b0);
    cycle();
    pcs.push_back(64'h8000_0040);
    foreach (pcs[k]) begin
      look(pcs[k]);
      exp = model_predict(vpc, lv);
      checks++;
      if (bp_o !== exp || bp_o.valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_miss_%0d got=%h exp=%h", k, bp_o, exp);
      end
      cycle();
    end
  endtask

  task automatic test_midreset();
    branchpredict_sbe exp;
    set_upd(64'h8000_0050, 64'h8000_0a00, 1'b1, 1'b0, 1'b0);
    cycle();
    rst = 1'b1;
    set_upd(64'h8000_0054, 64'h8000_0b00, 1'b1, 1'b0, 1'b0);
    cycle();
    look(64'h8000_0050);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_old got=%h exp=%h", bp_o, exp);
    end
    look(64'h8000_0054);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.valid !== 1'b0) begin
      failures++;
      $display("FAIL midreset_concurrent got=%h exp=%h", bp_o, exp);
    end
    set_upd(64'h8000_0058, 64'h8000_0c00, 1'b1, 1'b0, 1'b0);
    cycle();
    look(64'h8000_0058);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.predict_taken !== 1'b1) begin
      failures++;
      $display("FAIL midreset_alloc got=%h exp=%h", bp_o, exp);
    end
    set_upd(64'h8000_0058, '0, 1'b0, 1'b0, 1'b0);
    cycle();
    look(64'h8000_0058);
    exp = model_predict(vpc, lv);
    checks++;
    if (bp_o !== exp || bp_o.predict_taken !== 1'b0 || bp_o.valid !== 1'b1) begin
      failures++;
      $display("FAIL midreset_cnt10 got=%h exp=%h", bp_o, exp);
    end
  endtask

  function automatic logic [63:0] rand_pc();
    logic [63:0] bases [3];
    bases[0] = 64'h8000_0000;
    bases[1] = 64'h8000_0100;
    bases[2] = 64'h9000_0000;
    return bases[$urandom_range(0, 2)] + 64'($urandom_range(0, 15) * 4) + 64'($urandom_range(0, 1) * 2);
  endfunction

  task automatic test_random();
    branchpredict_sbe exp;
    int r;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if (r < 60) set_upd(rand_pc(), {$urandom, $urandom}, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
      else if (r < 70) set_upd(rand_pc(), '0, 1'b0, 1'b0, 1'b1);
      else upd = '0;
      flush = ($urandom_range(0, 99) < 2);
      rst = ($urandom_range(0, 199) < 1);
      vpc = rand_pc();
      lv = ($urandom_range(0, 9) != 0);
      #1;
      exp = model_predict(vpc, lv);
      checks++;
      if (bp_o !== exp) begin
        failures++;
        $display("FAIL random_%0d pc=%h got=%h exp=%h", n, vpc, bp_o, exp);
      end
      cycle();
    end
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; upd = '0; lv = 1'b0; vpc = '0;
    test_reset();
    test_alloc();
    test_alias();
    test_counter();
    test_clear();
    test_flush();
    test_midreset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
